// File: rtl/piso_stream_tx.sv
// Parallel-in/serial-out transmitter, MSB first, with a one-word holding buffer for gapless frames.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_stream_tx #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             frame_done
);
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_sh, w_sh_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_hold, w_hold_nxt;
  logic               r_hold_full, w_hold_full_nxt;
  logic               r_sout, w_sout_nxt;
  logic               r_done, w_done_nxt;
`ifdef PISO_PARITY_EN
  logic               r_par, w_par_nxt;
`endif
  logic               w_accept, w_last, w_start;
  logic [WIDTH-1:0]   w_src;

  assign w_accept = load && !r_hold_full;

  // r_cnt counts frame bits still to come after the one currently on sout.
  always_comb begin
    w_state_nxt     = r_state;
    w_sh_nxt        = r_sh;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_sout_nxt      = IDLE_BIT;
    w_start         = 1'b0;
    w_last          = 1'b0;
    w_src           = din;
`ifdef PISO_PARITY_EN
    w_par_nxt       = r_par;
`endif
    case (r_state)
      S_IDLE: w_start = w_accept;
      S_SHIFT: begin
        if (r_cnt != '0) begin
          w_sout_nxt = r_sh[WIDTH-1];
          w_sh_nxt   = {r_sh[WIDTH-2:0], 1'b0};
          w_cnt_nxt  = r_cnt - CW'(1);
        end else begin
`ifdef PISO_PARITY_EN
          w_state_nxt = S_PARITY;
          w_sout_nxt  = r_par;
`else
          w_last      = 1'b1;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: w_last = 1'b1;
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_accept && r_state == S_SHIFT && !w_last) begin
      w_hold_nxt      = din;
      w_hold_full_nxt = 1'b1;
    end

    // Last frame bit: chain the held word, else a word offered right now, else go idle.
    if (w_last) begin
      if (r_hold_full) begin
        w_start         = 1'b1;
        w_src           = r_hold;
        w_hold_full_nxt = 1'b0;
      end else if (w_accept) begin
        w_start = 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end

    if (w_start) begin
      w_state_nxt = S_SHIFT;
      w_sout_nxt  = w_src[WIDTH-1];
      w_sh_nxt    = {w_src[WIDTH-2:0], 1'b0};
      w_cnt_nxt   = CNT_LAST;
`ifdef PISO_PARITY_EN
      w_par_nxt   = ^w_src;
`endif
    end

`ifdef PISO_PARITY_EN
    w_done_nxt = (w_state_nxt == S_PARITY);
`else
    w_done_nxt = (w_state_nxt == S_SHIFT) && (w_cnt_nxt == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_sout      <= IDLE_BIT;
      r_done      <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_sh        <= w_sh_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_sout      <= w_sout_nxt;
      r_done      <= w_done_nxt;
`ifdef PISO_PARITY_EN
      r_par       <= w_par_nxt;
`endif
    end
  end

  assign ready      = !r_hold_full;
  assign sout       = r_sout;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_done;

endmodule

// File: doc/piso_stream_tx.md
# piso_stream_tx

Parallel-in/serial-out transmitter that turns handshaked parallel words into a continuous one-bit-per-clock serial stream, MSB first. It sits directly upstream of the team's serial sequence detectors: `sout` connects to the detector's serial input, and `sout` is sampled every clock. When no data is pending, the line is held at a fixed idle level. A one-word holding buffer allows back-to-back frames with no idle gap.

## Interface
- `WIDTH`, default 8: data word width in bits; legal range is 2 to 32.
- `IDLE_BIT`, default 1'b1: value driven on `sout` when no frame is being sent. The default of 1 cannot form the pattern 0-0-1 on its own.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `din` input, WIDTH bits: word to transmit; sampled when `load && ready`.
- `load` input, 1 bit: valid strobe for `din`.
- `ready` output, 1 bit: high when the block can accept a word. Equals "holding buffer empty".
- `sout` output, 1 bit: registered serial data.
- `busy` output, 1 bit: registered; high while `sout` is carrying frame bits.
- `frame_done` output, 1 bit: registered one-cycle pulse, coincident with the last bit of a frame on `sout`.

## Operation
- Datapath:
  - Shift register `sh[WIDTH-1:0]`.
  - Holding register `hold[WIDTH-1:0]` plus flag `hold_full`.
  - Bit counter `cnt`, width ceil(log2(WIDTH+1)).
- The FSM has two states, plus an optional third (see Configuration).
- IDLE state:
  - `sout = IDLE_BIT`, `busy = 0`.
  - On `load && ready`, load `din` into `sh`, set `cnt = WIDTH-1`, and go to SHIFT. `hold` is not used on this path.
- SHIFT state:
  - Each cycle, `sout = sh[WIDTH-1]` and `sh` shifts left by one (zero fill). `cnt` decrements.
  - An accept (`load && ready`) during SHIFT writes `din` into `hold` and sets `hold_full`.
- Last bit of a frame (`cnt == 0`; in PARITY state when configured):
  - If `hold_full`: move `hold` into `sh`, clear `hold_full`, reload `cnt`, and stay in SHIFT. This is gapless.
  - Else, if `load && ready` in that same cycle: load `din` directly into `sh` and stay in SHIFT. This is also gapless.
  - Else: go to IDLE.
- Simultaneous events:
  - An accept and a `hold` drain in the same cycle cannot happen, because `ready = !hold_full`.
  - `load` while `ready = 0` is ignored; `din` is not captured. No error flag is raised.
- Reset, asserted at any time, including mid-frame:
  - State goes to IDLE; `hold` is discarded; `cnt = 0`.
  - Outputs: `sout = IDLE_BIT`, `busy = 0`, `frame_done = 0`, `ready = 1`.
  - The partial frame is not resumed.

## Timing
- Accept occurs at rising edge k, with `load && ready` high.
- From IDLE, the first bit (`din[WIDTH-1]`) is on `sout` in cycle k+1. Latency is 1 clock.
- Frame length is WIDTH cycles, or WIDTH+1 when parity is enabled.
- `frame_done` is high in the cycle the final frame bit is on `sout`.
- In gapless chaining, the next frame's MSB appears in the cycle immediately after `frame_done`.
- `busy` goes low in the first cycle `sout` returns to `IDLE_BIT`.
- `ready` falls in the cycle after `hold` is written. It rises in the cycle after `hold` drains into `sh`.
- A second word can therefore be accepted at any time during a frame. A third word must wait until the current frame's last bit.

## Configuration
- Macro `PISO_PARITY_EN`.
- Defined:
  - A PARITY state follows the last data bit, driving `sout` = even parity (XOR of all WIDTH data bits). The XOR is computed at load time and stored with the word.
  - `frame_done` accompanies the parity bit.
  - Frame length is WIDTH+1.
  - The last-bit chaining rules apply in PARITY instead of at `cnt == 0`.
- Undefined: no PARITY state, no parity storage, frame length is WIDTH.

## Test plan
- Reset and single frame (WIDTH=8, parity off):
  - Stimulus: hold `rst_n` low, release it, then accept `din = 8'h23` at edge k.
  - Required: during reset and until k, `sout = 1`, `busy = 0`, `ready = 1`.
  - Required: cycles k+1..k+8 show `sout` = 0,0,1,0,0,0,1,1.
  - Required: `frame_done` high at k+8 only; cycle k+9 has `sout = 1`, `busy = 0`.
- Back-to-back frames:
  - Stimulus: accept 8'hA5 at edge k, then 8'h3C at k+2.
  - Required: `ready` is 0 from k+3 until k+9, when 8'h3C drains from `hold` into `sh`.
  - Required: `sout` shows the bits of A5 in cycles k+1..k+8, then the bits of 3C in k+9..k+16, with no idle cycle.
  - Required: `frame_done` at k+8 and k+16.
- Same-cycle chaining: accept 8'hFF, then hold `load` high with 8'h00 so it is accepted while `hold` is empty during the last-bit cycle -> `sout` shows eight 1s followed immediately by eight 0s.
- Overrun ignored: accept three words at k, k+1 and k+2 -> the third word is not transmitted, and only two frames appear on `sout`.
- Reset mid-frame: pull `rst_n` low at k+4 during 8'h0F -> `sout` goes to 1 asynchronously, `busy = 0` and `ready = 1`; no remaining bits appear after release.
- With `PISO_PARITY_EN`:
  - Required: `din = 8'h07` gives 9 bits, 0,0,0,0,0,1,1,1 then 1.
  - Required: `din = 8'h03` ends with parity 0.
  - Required: `frame_done` is on the ninth bit.
